// File: rtl/bf_loader.sv
// Upstream feeder for the byte-stream Brainfuck core: filters and validates a program, then buffers runtime input.
// Define BF_LOADER_BRACKET_CHECK_EN to enable the bracket nesting counter and its error checks.
module bf_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int NEST_W     = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       src_valid,
    output logic       src_ack,
    input  logic [7:0] src_data,
    input  logic       src_last,
    input  logic       ready,
    output logic       in_valid,
    input  logic       in_ack,
    output logic [7:0] in_data,
    output logic       start,
    output logic       busy,
    output logic       err,
    output logic [7:0] prog_len
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_LOAD, S_TERM, S_START, S_RUN, S_ERR} state_e;

    state_e        state_q, state_d;
    logic          hv_q, hv_d;
    logic [7:0]    hd_q, hd_d;
    logic          last_q, last_d;
    logic [7:0]    len_q, len_d;
    logic          armed_q, armed_d;
    logic          src_ack_q, src_ack_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic fifoPush, fifoPop, fifoEmpty, bracketErr, nestOpen;

    function automatic logic isInstr(input logic [7:0] b);
        return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
    endfunction

`ifdef BF_LOADER_BRACKET_CHECK_EN
    logic [NEST_W-1:0] nest_q, nest_d;

    assign bracketErr = (src_data == 8'h5D && nest_q == '0) || (src_data == 8'h5B && (&nest_q));
    assign nestOpen   = (nest_q != '0);
`else
    assign bracketErr = 1'b0;
    assign nestOpen   = 1'b0;
`endif

    assign fifoEmpty = (cnt_q == '0);
    assign fifoPush  = (state_q == S_RUN) && src_valid && src_ack;
    assign fifoPop   = (state_q == S_RUN) && in_valid && in_ack;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_LOAD;
            hv_q      <= 1'b0;
            hd_q      <= 8'h00;
            last_q    <= 1'b0;
            len_q     <= 8'h00;
            armed_q   <= 1'b0;
            src_ack_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
            nest_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hv_q      <= hv_d;
            hd_q      <= hd_d;
            last_q    <= last_d;
            len_q     <= len_d;
            armed_q   <= armed_d;
            src_ack_q <= src_ack_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
`ifdef BF_LOADER_BRACKET_CHECK_EN
            nest_q    <= nest_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (fifoPush) mem_q[wr_q] <= src_data;
    end

    always_comb begin
        state_d = state_q;
        hv_d    = hv_q;
        hd_d    = hd_q;
        last_d  = last_q;
        len_d   = len_q;
        armed_d = armed_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
`ifdef BF_LOADER_BRACKET_CHECK_EN
        nest_d  = nest_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ack) hv_d = 1'b0;
                if (src_valid && src_ack) begin
                    if (src_last) last_d = 1'b1;
                    if (isInstr(src_data)) begin
                        // The terminator needs the last memory slot, so 255 is the longest program.
                        if (len_q == 8'hFF || bracketErr) begin
                            state_d = S_ERR;
                        end else begin
                            hv_d  = 1'b1;
                            hd_d  = src_data;
                            len_d = len_q + 8'd1;
`ifdef BF_LOADER_BRACKET_CHECK_EN
                            if (src_data == 8'h5B)      nest_d = nest_q + NEST_W'(1);
                            else if (src_data == 8'h5D) nest_d = nest_q - NEST_W'(1);
`endif
                        end
                    end
                end else if (!hv_q && last_q) begin
                    state_d = nestOpen ? S_ERR : S_TERM;
                end
            end
            S_TERM: begin
                if (in_valid && in_ack) state_d = S_START;
            end
            S_START: begin
                if (ready) begin
                    state_d = S_RUN;
                    armed_d = 1'b0;
                end
            end
            S_RUN: begin
                armed_d = 1'b1;
                if (fifoPush) wr_d = wr_q + PW'(1);
                if (fifoPop)  rd_d = rd_q + PW'(1);
                cnt_d = cnt_q + (PW+1)'(fifoPush) - (PW+1)'(fifoPop);
                // The core may still show ready in the cycle right after start, so ignore it once.
                if (armed_q && ready) begin
                    state_d = S_LOAD;
                    armed_d = 1'b0;
                    wr_d    = '0;
                    rd_d    = '0;
                    cnt_d   = '0;
                    len_d   = 8'h00;
                    hv_d    = 1'b0;
                    last_d  = 1'b0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
                    nest_d  = '0;
`endif
                end
            end
            default: ;
        endcase
    end

    // src_ack is precomputed from next state so it never depends on ready or in_ack.
    always_comb begin
        src_ack_d = 1'b0;
        case (state_d)
            S_LOAD:  src_ack_d = !hv_d && !last_d;
            S_RUN:   src_ack_d = !cnt_d[PW];
            default: ;
        endcase
    end

    always_comb begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_valid = hv_q && ready;
                in_data  = hd_q;
            end
            S_TERM:  in_valid = ready;
            S_START: start = ready;
            S_RUN: begin
                // Bytes offered while ready is high would be taken as program bytes.
                in_valid = !fifoEmpty && !ready;
                in_data  = fifoEmpty ? 8'h00 : mem_q[rd_q];
            end
            default: ;
        endcase
    end

    assign src_ack  = src_ack_q;
    assign busy     = (state_q != S_LOAD);
    assign err      = (state_q == S_ERR);
    assign prog_len = len_q;

endmodule
